loss_tile_scheduler: RTL and testbench

Sequences the squared-difference loss datapath over a whole feature map held as `N_TILES` tiles of 64 pixels. On `start`, it streams tile addresses to the content and generated pixel buffers and pushes each returned tile pair through a pipelined squared-difference and adder-tree stage. It accumulates the per-tile sums and reports `loss = floor(total/2)`, saturated to 16 bits. It sits between the tile buffers and the optimiser control, and replaces single-tile combinational loss evaluation.

---
 rtl/loss_pkg.sv | 36 +++
 rtl/sq_diff_tree.sv | 82 ++++++++
 rtl/loss_tile_scheduler.sv | 154 +++++++++++++++
 tb/tb_loss_tile_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loss_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loss_pkg
// Description : Shared defaults, width helpers and FSM state encoding for the
//               tiled squared-difference loss scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package loss_pkg;

    localparam int LOSS_PIX_W = 16;
    localparam int LOSS_LANES = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loss_state_t;

    // Width of one lane square; 65535^2 still fits in 2*PIX_W bits.
    function automatic int sq_w(input int pix_w);
        return 2 * pix_w;
    endfunction

    // Width of the sum of all lane squares of one tile.
    function automatic int tile_sum_w(input int pix_w, input int lanes);
        return 2 * pix_w + $clog2(lanes);
    endfunction

    // Accumulator width over a whole evaluation; one spare bit so it never wraps.
    function automatic int acc_w(input int n_tiles, input int pix_w, input int lanes);
        return tile_sum_w(pix_w, lanes) + $clog2(n_tiles) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sq_diff_tree.sv
`default_nettype none
// ============================================================================
// Module      : sq_diff_tree
// Description : Two-stage pipeline: registered per-lane squared differences,
//               then a registered adder-tree sum. A valid bit travels with
//               the data and is cleared by flush or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sq_diff_tree
    import loss_pkg::*;
#(
    parameter int PIX_W = LOSS_PIX_W,
    parameter int LANES = LOSS_LANES
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_valid,
    input  logic                                   i_flush,
    input  logic [LANES-1:0][PIX_W-1:0]            i_content,
    input  logic [LANES-1:0][PIX_W-1:0]            i_generated,
    output logic                                   o_valid,
    output logic [tile_sum_w(PIX_W, LANES)-1:0]    o_sum
);

    localparam int SQ_W = sq_w(PIX_W);
    localparam int TS_W = tile_sum_w(PIX_W, LANES);
    localparam int DW   = 2 * PIX_W + 2;

    logic signed [DW-1:0]   w_diff [LANES];
    logic        [SQ_W-1:0] w_sq   [LANES];
    logic        [SQ_W-1:0] r_sq   [LANES];
    logic        [TS_W-1:0] w_sum;
    logic        [TS_W-1:0] r_sum;
    logic                   r_v1;
    logic                   r_v2;

    // Signed difference of zero-extended pixels, squared; the true square is
    // non-negative and below 2^SQ_W so the low bits carry it exactly.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_diff[i] = $signed({{(PIX_W+2){1'b0}}, i_content[i]})
                      - $signed({{(PIX_W+2){1'b0}}, i_generated[i]});
            w_sq[i]   = SQ_W'(w_diff[i] * w_diff[i]);
        end
    end

    // Adder tree over the registered lane squares.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + TS_W'(r_sq[i]);
        end
    end

    // Valid pipeline; flush drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
        end
    end

    // Data stages, loaded only when their input is valid.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            for (int i = 0; i < LANES; i++) begin
                r_sq[i] <= w_sq[i];
            end
        end
        if (r_v1) begin
            r_sum <= w_sum;
        end
    end

    assign o_valid = r_v2;
    assign o_sum   = r_sum;

endmodule
`default_nettype wire

// File: rtl/loss_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : loss_tile_scheduler
// Description : Streams N_TILES tile reads through the squared-difference
//               pipeline, accumulates the tile sums and reports
//               min(floor(total/2), 16'hFFFF) with a saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module loss_tile_scheduler
    import loss_pkg::*;
#(
    parameter int PIX_W   = LOSS_PIX_W,
    parameter int LANES   = LOSS_LANES,
    parameter int N_TILES = 16
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            start,
    input  logic                                            abort,
    output logic                                            rd_en,
    output logic [((N_TILES > 1) ? $clog2(N_TILES) : 1)-1:0] tile_addr,
    input  logic [LANES-1:0][PIX_W-1:0]                     content_tile,
    input  logic [LANES-1:0][PIX_W-1:0]                     generated_tile,
    output logic                                            busy,
    output logic                                            done,
    output logic [15:0]                                     loss_out,
    output logic                                            loss_sat
);

    localparam int             AW        = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int             TS_W      = tile_sum_w(PIX_W, LANES);
    localparam int             ACC_W     = acc_w(N_TILES, PIX_W, LANES);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(N_TILES - 1);

    loss_state_t        r_state;
    loss_state_t        w_state_next;
    logic [AW-1:0]      r_addr;
    logic [1:0]         r_drain;
    logic               r_rd_d;
    logic               w_abort;
    logic               w_accept;
    logic               w_tile_v;
    logic [TS_W-1:0]    w_tile_sum;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-2:0]   w_half;
    logic               w_sat_next;
    logic [15:0]        r_loss;
    logic               r_sat;

    assign w_abort  = abort && ((r_state == ST_FETCH) || (r_state == ST_DRAIN));
    assign w_accept = (r_state == ST_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        w_state_next = r_state;
        rd_en        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (w_abort)                 w_state_next = ST_IDLE;
                else if (r_addr == LAST_ADDR) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_abort)              w_state_next = ST_IDLE;
                else if (r_drain == 2'd2) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Address counter, drain counter and read-return valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_drain <= '0;
            r_rd_d  <= 1'b0;
        end else begin
            r_rd_d <= rd_en && !w_abort;
            if (w_accept) begin
                r_addr <= '0;
            end else if ((r_state == ST_FETCH) && (r_addr != LAST_ADDR) && !w_abort) begin
                r_addr <= r_addr + AW'(1);
            end
            if (r_state == ST_DRAIN) r_drain <= r_drain + 2'd1;
            else                     r_drain <= 2'd0;
        end
    end

    sq_diff_tree #(
        .PIX_W (PIX_W),
        .LANES (LANES)
    ) u_sq_diff_tree (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (r_rd_d),
        .i_flush     (w_abort),
        .i_content   (content_tile),
        .i_generated (generated_tile),
        .o_valid     (w_tile_v),
        .o_sum       (w_tile_sum)
    );

    assign w_acc_next = r_acc + (w_tile_v ? ACC_W'(w_tile_sum) : '0);
    assign w_half     = w_acc_next[ACC_W-1:1];
    assign w_sat_next = |w_half[ACC_W-2:16];

    // Accumulator, restarted whenever a new evaluation is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n || w_accept) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    // Result register: captures the final total as DONE is entered, so the
    // new value is visible in the same cycle as done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_loss <= '0;
            r_sat  <= 1'b0;
        end else if ((r_state == ST_DRAIN) && (w_state_next == ST_DONE)) begin
            r_loss <= w_sat_next ? 16'hFFFF : w_half[15:0];
            r_sat  <= w_sat_next;
        end
    end

    assign tile_addr = r_addr;
    assign loss_out  = r_loss;
    assign loss_sat  = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_loss_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_loss_tile_scheduler
// Description : Self-checking bench: tile-buffer models, scoreboard of
//               expected loss results, N=16 and N=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loss_tile_scheduler;

    localparam int PW = 16;
    localparam int LN = 64;
    localparam int NT = 16;

    typedef struct {
        logic [15:0] loss;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n, start, abort;
    logic                  rd_en, busy, done, loss_sat;
    logic [3:0]            tile_addr;
    logic [LN-1:0][PW-1:0] ctile, gtile;
    logic [15:0]           loss_out;

    logic                  start1, abort1;
    logic                  rd_en1, busy1, done1, sat1;
    logic [0:0]            addr1;
    logic [LN-1:0][PW-1:0] ctile1, gtile1;
    logic [15:0]           loss1;

    logic [PW-1:0] cmem [NT][LN];
    logic [PW-1:0] gmem [NT][LN];
    logic [PW-1:0] c1mem [LN];
    logic [PW-1:0] g1mem [LN];

    exp_t exp_q[$];
    exp_t exp_q1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    loss_tile_scheduler #(.PIX_W(PW), .LANES(LN), .N_TILES(NT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_en(rd_en), .tile_addr(tile_addr),
        .content_tile(ctile), .generated_tile(gtile),
        .busy(busy), .done(done), .loss_out(loss_out), .loss_sat(loss_sat)
    );

    loss_tile_scheduler #(.PIX_W(PW), .LANES(LN), .N_TILES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .rd_en(rd_en1), .tile_addr(addr1),
        .content_tile(ctile1), .generated_tile(gtile1),
        .busy(busy1), .done(done1), .loss_out(loss1), .loss_sat(sat1)
    );

    // Tile buffer models: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int l = 0; l < LN; l++) begin
                ctile[l] <= cmem[tile_addr][l];
                gtile[l] <= gmem[tile_addr][l];
            end
        end
        if (rd_en1) begin
            for (int l = 0; l < LN; l++) begin
                ctile1[l] <= c1mem[l];
                gtile1[l] <= g1mem[l];
            end
        end
    end

    function automatic exp_t model16();
        exp_t   e;
        longint acc = 0;
        longint d;
        longint half;
        for (int t = 0; t < NT; t++) begin
            for (int l = 0; l < LN; l++) begin
                d   = longint'(cmem[t][l]) - longint'(gmem[t][l]);
                acc = acc + d * d;
            end
        end
        half   = acc >>> 1;
        e.sat  = (half > 65535);
        e.loss = e.sat ? 16'hFFFF : half[15:0];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int cv, input int gv);
        for (int t = 0; t < NT; t++) begin
            for (int l = 0; l < LN; l++) begin
                cmem[t][l] = PW'(cv);
                gmem[t][l] = PW'(gv);
            end
        end
    endtask

    // Full N=16 run from the current IDLE cycle; optional start pulses while busy.
    task automatic run_full(input string name, input bit pulse);
        exp_t e;
        bit   seen = 0;
        start = 1'b1;
        exp_q.push_back(model16());
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            n_cmp++;
            if (rd_en !== (c <= NT)) begin
                n_err++;
                $display("FAIL %s rd_en cycle %0d: got %b want %b", name, c, rd_en, (c <= NT));
            end
            if (c <= NT) begin
                n_cmp++;
                if (tile_addr !== 4'(c - 1)) begin
                    n_err++;
                    $display("FAIL %s tile_addr cycle %0d: got %0d want %0d", name, c, tile_addr, c - 1);
                end
            end
            if (done === 1'b1) begin
                seen = 1;
                e    = exp_q.pop_front();
                n_cmp += 4;
                if (c != NT + 4) begin
                    n_err++;
                    $display("FAIL %s done_cycle: got %0d want %0d", name, c, NT + 4);
                end
                if (loss_out !== e.loss) begin
                    n_err++;
                    $display("FAIL %s loss_out: got %h want %h", name, loss_out, e.loss);
                end
                if (loss_sat !== e.sat) begin
                    n_err++;
                    $display("FAIL %s loss_sat: got %b want %b", name, loss_sat, e.sat);
                end
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy_at_done: got %b want 0", name, busy);
                end
            end
            start = (pulse && (c == 3 || c == 10)) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got no done want done at cycle %0d", name, NT + 4);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        tick();
        tick();
        n_cmp += 3;
        if ({rd_en, busy, done, loss_sat} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset flags: got %b want 0000", {rd_en, busy, done, loss_sat});
        end
        if (loss_out !== 16'h0 || tile_addr !== 4'h0) begin
            n_err++;
            $display("FAIL reset loss/addr: got %h/%h want 0000/0", loss_out, tile_addr);
        end
        if ({rd_en1, busy1, done1, sat1} !== 4'b0000 || loss1 !== 16'h0) begin
            n_err++;
            $display("FAIL reset dut1: got %b/%h want 0000/0000", {rd_en1, busy1, done1, sat1}, loss1);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rate();
        fill(3, 1);
        run_full("rate", 1'b0);
    endtask

    task automatic test_sign_sat();
        fill(0, 65535);
        run_full("sat_c0", 1'b0);
        fill(65535, 0);
        run_full("sat_g0", 1'b0);
    endtask

    task automatic test_rounding();
        fill(100, 100);
        cmem[0][5] = 16'd101;
        run_full("round_d1", 1'b0);
        cmem[0][5] = 16'd103;
        run_full("round_d3", 1'b0);
    endtask

    task automatic test_start_pulses();
        fill(7, 2);
        run_full("pulses", 1'b1);
    endtask

    task automatic test_abort();
        int ndone = 0;
        fill(50, 50);
        cmem[0][0] = 16'd53;
        cmem[0][1] = 16'd52;
        cmem[0][2] = 16'd51;
        run_full("abort_pre", 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp += 3;
        if (rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL abort rd_en: got %b want 0", rd_en);
        end
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort busy: got %b want 0", busy);
        end
        if (loss_out !== 16'd7 || loss_sat !== 1'b0) begin
            n_err++;
            $display("FAIL abort hold: got %h/%b want 0007/0", loss_out, loss_sat);
        end
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1 || rd_en === 1'b1) ndone++;
            tick();
        end
        n_cmp++;
        if (ndone != 0) begin
            n_err++;
            $display("FAIL abort quiet: got %0d active cycles want 0", ndone);
        end
        fill(10, 13);
        run_full("abort_post", 1'b0);
    endtask

    task automatic test_reset_mid();
        fill(2, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({rd_en, busy, done, loss_sat} !== 4'b0000 || loss_out !== 16'h0 || tile_addr !== 4'h0) begin
            n_err++;
            $display("FAIL reset_mid: got %b/%h/%h want 0000/0000/0",
                     {rd_en, busy, done, loss_sat}, loss_out, tile_addr);
        end
        rst_n = 1'b1;
        run_full("reset_mid_after", 1'b0);
    endtask

    // N=1 with start held: accept at cycles 0,6,12 and done at 5,11,17.
    task automatic test_back_to_back();
        exp_t e;
        exp_t m;
        for (int l = 0; l < LN; l++) begin
            c1mem[l] = 16'd2;
            g1mem[l] = 16'd0;
        end
        m.loss = 16'd128;
        m.sat  = 1'b0;
        start1 = 1'b1;
        exp_q1.push_back(m);
        tick();
        for (int c = 1; c <= 17; c++) begin
            n_cmp += 2;
            if (done1 !== ((c % 6) == 5)) begin
                n_err++;
                $display("FAIL b2b done cycle %0d: got %b want %b", c, done1, ((c % 6) == 5));
            end
            if (rd_en1 !== ((c % 6) == 1) || (rd_en1 === 1'b1 && addr1 !== 1'b0)) begin
                n_err++;
                $display("FAIL b2b rd_en cycle %0d: got %b/%b want %b/0", c, rd_en1, addr1, ((c % 6) == 1));
            end
            if (done1 === 1'b1 && exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                n_cmp++;
                if (loss1 !== e.loss || sat1 !== e.sat) begin
                    n_err++;
                    $display("FAIL b2b loss cycle %0d: got %h/%b want %h/%b", c, loss1, sat1, e.loss, e.sat);
                end
            end
            if ((c % 6) == 0) exp_q1.push_back(m);
            tick();
        end
        start1 = 1'b0;
        tick();
        n_cmp++;
        if (exp_q1.size() != 0) begin
            n_err++;
            $display("FAIL b2b pending: got %0d results outstanding want 0", exp_q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_sign_sat();
        test_rounding();
        test_start_pulses();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
